// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register word offsets and STATUS bit positions.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Word offsets, i.e. addr[3:2]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int unsigned ST_BIT_ACTIVE = 0;
  localparam int unsigned ST_BIT_FULL   = 1;
  localparam int unsigned ST_BIT_EMPTY  = 2;
  localparam int unsigned ST_BIT_OVF    = 3;
  localparam int unsigned ST_BIT_CNT    = 4;

  // A divider below 2 cannot frame a bit, so it is raised to 2.
  function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] v);
    return (v < BAUD_W'(2)) ? BAUD_W'(2) : v;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous first-word-fall-through FIFO holding bytes awaiting
// serialisation; pushes when full and pops when empty are ignored.
module mmio_uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory port:
// bus decode, TX/STATUS/BAUD_DIV registers, FIFO and bit-serialising FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned       CLKS_PER_BIT = 16,
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic             write_en,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] out_data,
  output logic             hit,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        off;
  logic              wr_hit, push_req, pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [WIDTH-1:0]  status_w;
  logic              unused_bits;

  assign off         = addr[3:2];
  assign hit         = (addr[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign wr_hit      = write_en & hit;
  assign push_req    = wr_hit & (off == OFF_TXDATA);
  assign unused_bits = ^{addr[1:0], write_data[WIDTH-1:BAUD_W]};

  mmio_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_req),
    .wdata_i (write_data[BYTE_W-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= BAUD_W'(CLKS_PER_BIT);
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Each bit period reloads the counter from the divider in force at that
  // boundary, so a divider write never stretches the bit already on the line.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;

    if (wr_hit && (off == OFF_BAUD)) baud_d = clamp_baud(write_data[BAUD_W-1:0]);
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_hit && (off == OFF_STATUS) && write_data[ST_BIT_OVF]) begin
      ovf_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
          shift_d = fifo_rdata;
          cnt_d   = baud_q - BAUD_W'(1);
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          bit_d   = '0;
          cnt_d   = baud_q - BAUD_W'(1);
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q - BAUD_W'(1);
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
            shift_d = fifo_rdata;
            cnt_d   = baud_q - BAUD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Load data path: a pure decode of the bus inputs and current registers.
  always_comb begin
    status_w                     = '0;
    status_w[ST_BIT_ACTIVE]      = (state_q != ST_IDLE);
    status_w[ST_BIT_FULL]        = fifo_full;
    status_w[ST_BIT_EMPTY]       = fifo_empty;
    status_w[ST_BIT_OVF]         = ovf_q;
    status_w[ST_BIT_CNT +: 4]    = 4'(fifo_count);
    out_data                     = '0;
    if (read_en && hit) begin
      case (off)
        OFF_STATUS: out_data = status_w;
        OFF_BAUD:   out_data = WIDTH'(baud_q);
        OFF_RSVD:   out_data = '0;
        default:    out_data = '0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timing-level model predicts accepted
// bytes and frame start cycles; a monitor decodes tx and compares.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] out_data;
  logic        hit, tx, busy;

  mmio_uart_tx #(
    .WIDTH(32), .BASE_ADDR(BASE), .CLKS_PER_BIT(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .addr(addr), .write_data(write_data), .out_data(out_data),
    .hit(hit), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is 10 bit periods; a byte written at edge c
  // starts at max(c+1, end of previous frame); FIFO holds bytes not yet started.
  typedef struct { logic [7:0] data; longint s; } frame_t;
  frame_t exp_q[$];
  longint st_q[$];
  longint last_end = 0;
  bit     ovf_m = 1'b0;
  int     baud_m = 16;
  bit     mon_en = 1'b1;

  function automatic void mdl_write(input logic [3:0] off, input logic [31:0] d, input longint c);
    case (off[3:2])
      2'd0: begin
        int occ = 0;
        foreach (st_q[i]) if (st_q[i] >= c) occ++;
        if (occ >= DEPTH) ovf_m = 1'b1;
        else begin
          frame_t f;
          f.s    = (last_end > c + 1) ? last_end : c + 1;
          f.data = d[7:0];
          st_q.push_back(f.s);
          last_end = f.s + 10 * baud_m;
          exp_q.push_back(f);
        end
      end
      2'd1: if (d[3]) ovf_m = 1'b0;
      2'd2: begin
        baud_m = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
        st_q.delete();
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] mdl_status(input longint now);
    int cnt = 0;
    bit act = 1'b0;
    foreach (st_q[i]) begin
      if (st_q[i] > now) cnt++;
      else if (now < st_q[i] + 10 * baud_m) act = 1'b1;
    end
    return {24'b0, 4'(cnt), ovf_m, (cnt == 0), (cnt == DEPTH), act};
  endfunction

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input bit use_model);
    @(negedge clk);
    addr = BASE | 32'(off); write_data = d; write_en = 1'b1; read_en = 1'b0;
    if (use_model) mdl_write(off, d, cyc + 1);
  endtask

  task automatic idle();
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit, input string name);
    @(negedge clk);
    addr = a; read_en = 1'b1; write_en = 1'b0;
    #1;
    chk(name, out_data, exp);
    chk({name, "_hit"}, hit, exp_hit);
  endtask

  task automatic rd_stat(input string name);
    logic [31:0] e;
    @(negedge clk);
    addr = BASE | 32'h4; read_en = 1'b1; write_en = 1'b0;
    e = mdl_status(cyc);
    #1;
    chk(name, out_data, e);
  endtask

  task automatic wait_to(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget = 20000;
    idle();
    while ((cyc < last_end + 1 || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({name, "_pending_frames"}, exp_q.size(), 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  // Monitor: on each start bit, pop the expected frame and check start cycle,
  // every sample of all ten bit periods, and the mid-bit decoded byte.
  always begin : monitor
    longint     st;
    int         b, mism;
    logic [7:0] got;
    frame_t     f;
    @(negedge clk);
    if (mon_en && rst && tx === 1'b0) begin
      st = cyc; b = baud_m; mism = 0; got = '0;
      chk("frame_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) f = exp_q.pop_front();
      else begin f.data = '0; f.s = -1; end
      for (int k = 0; k < 10 * b; k++) begin
        int   sl;
        logic eb;
        if (k > 0) @(negedge clk);
        sl = k / b;
        eb = (sl == 0) ? 1'b0 : (sl == 9) ? 1'b1 : f.data[sl-1];
        if (tx !== eb) mism++;
        if (sl >= 1 && sl <= 8 && (k % b) == b / 2) got[sl-1] = tx;
      end
      chk("frame_start", st, f.s);
      chk("frame_data", got, f.data);
      chk("frame_shape", mism, 0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  initial begin : stim
    longint s;
    int     zeros;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    rd(BASE | 32'h4, 32'h4, 1'b1, "status_after_reset");
    rd(BASE | 32'h8, 32'd16, 1'b1, "baud_after_reset");
    rd(32'h0000_2000, 32'h0, 1'b0, "miss_addr");
    rd(BASE | 32'h0, 32'h0, 1'b1, "txdata_reads_zero");
    rd(BASE | 32'hC, 32'h0, 1'b1, "reserved_reads_zero");

    // Single frame at BAUD_DIV=4, busy until the stop bit ends.
    wr(4'h8, 32'd4, 1'b1);
    wr(4'h0, 32'hA5, 1'b1);
    s = st_q[$];
    idle();
    wait_to(s + 39);
    chk("busy_in_stop", busy, 1);
    wait_to(s + 40);
    chk("busy_after_stop", busy, 0);
    chk("tx_idle_after", tx, 1);
    drain("single");

    wr(4'h0, 32'h11, 1'b1);
    wr(4'h0, 32'h22, 1'b1);
    drain("back_to_back");

    for (int i = 0; i < 6; i++) wr(4'h0, 32'h31 + 32'(i), 1'b1);
    rd_stat("overflow_status");
    chk("overflow_sticky", out_data[3], 1);
    wr(4'h4, 32'h8, 1'b1);
    rd_stat("overflow_cleared");
    drain("overflow");

    wr(4'h8, 32'd1, 1'b1);
    rd(BASE | 32'h8, 32'd2, 1'b1, "baud_clamp_1");
    wr(4'h8, 32'd0, 1'b1);
    rd(BASE | 32'h8, 32'd2, 1'b1, "baud_clamp_0");
    wr(4'h8, 32'd4, 1'b1);

    // Simultaneous read and write: read sees the old divider.
    @(negedge clk);
    addr = BASE | 32'h8; write_data = 32'd6; write_en = 1'b1; read_en = 1'b1;
    #1;
    chk("rw_same_cycle_old", out_data, 32'd4);
    mdl_write(4'h8, 32'd6, cyc + 1);
    rd(BASE | 32'h8, 32'd6, 1'b1, "rw_same_cycle_new");
    wr(4'h8, 32'd4, 1'b1);

    // Divider change inside the start bit only affects the following bits.
    idle();
    mon_en = 1'b0;
    wr(4'h0, 32'h01, 1'b0);
    s = cyc + 2;
    idle();
    wait_to(s);
    chk("midbit_start_low", tx, 0);
    wr(4'h8, 32'd8, 1'b1);
    idle();
    wait_to(s + 3);
    chk("midbit_start_old_len", tx, 0);
    wait_to(s + 4);
    chk("midbit_bit0_begin", tx, 1);
    wait_to(s + 11);
    chk("midbit_bit0_new_len", tx, 1);
    wait_to(s + 12);
    chk("midbit_bit1_begin", tx, 0);
    begin
      int budget = 500;
      while (busy && budget > 0) begin @(negedge clk); budget--; end
    end
    chk("midbit_drain_busy", busy, 0);
    wr(4'h8, 32'd4, 1'b1);
    idle();
    mon_en = 1'b1;

    // Randomised bursts with interleaved STATUS reads.
    for (int burst = 0; burst < 10; burst++) begin
      logic [31:0] bd;
      bd = 32'($urandom_range(0, 5));
      wr(4'h8, bd, 1'b1);
      rd(BASE | 32'h8, 32'(baud_m), 1'b1, "rand_baud");
      wr(4'h4, 32'h8, 1'b1);
      for (int n = $urandom_range(1, 7); n > 0; n--) begin
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
        for (int g = 0; g < gap; g++) begin
          if ($urandom_range(0, 1) == 1) rd_stat("rand_status");
          else idle();
        end
        wr(4'h0, $urandom, 1'b1);
      end
      rd_stat("rand_status_end");
      drain("rand_burst");
    end

    // Asynchronous reset in the middle of a data bit.
    wr(4'h8, 32'd4, 1'b1);
    idle();
    mon_en = 1'b0;
    wr(4'h0, 32'h5A, 1'b0);
    s = cyc + 2;
    idle();
    wait_to(s + 10);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    baud_m = 16; ovf_m = 1'b0; st_q.delete();
    rd(BASE | 32'h4, 32'h4, 1'b1, "status_after_midframe_rst");
    rd(BASE | 32'h8, 32'd16, 1'b1, "baud_after_midframe_rst");
    idle();
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    chk("no_residual_frame", zeros, 0);
    chk("idle_busy_after_rst", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
